// File: rtl/cache_tag_ctrl_pkg.sv
// Shared types for the cache tag controller: tag entry layout, PLRU state and FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cache_def_pipe_data;

    localparam int WAYS  = 4;
    localparam int TAG_W = 18;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } cache_tag_type;

    // Tree pseudo-LRU: b[0] picks the half, b[1] the way within {0,1}, b[2] within {2,3}
    typedef logic [2:0] plru_t;

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_READY     = 2'd1,
        ST_MISS_WAIT = 2'd2
    } ctrl_state_t;

    function automatic logic [1:0] plru_victim(input plru_t b);
        if (b[0]) begin
            return b[2] ? 2'd3 : 2'd2;
        end
        return b[1] ? 2'd1 : 2'd0;
    endfunction

    // Point the tree away from the way just used; untouched subtree keeps its bit
    function automatic plru_t plru_touch(input plru_t b, input logic [1:0] w);
        plru_t n;
        n = b;
        case (w)
            2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
            2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
            2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
            default: begin n[0] = 1'b0; n[2] = 1'b0; end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cache_tag_ctrl_plru.sv
// Per-set 3-bit tree PLRU state with clear and touch write ports and a combinational read.
// Latency: read is combinational; clear/touch take effect on the next edge.
// Backpressure: none; clear wins over touch when both are requested.
module cache_plru_array
    import cache_def_pipe_data::*;
#(
    parameter int SET_NUM = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_en,
    input  logic [$clog2(SET_NUM)-1:0] clr_idx,
    input  logic                       touch_en,
    input  logic [$clog2(SET_NUM)-1:0] touch_idx,
    input  logic [1:0]                 touch_way,
    input  logic [$clog2(SET_NUM)-1:0] rd_idx,
    output plru_t                      rd_plru
);

    plru_t mem [SET_NUM];

    // Whole array clears on reset; sweep clear and touch update one set per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SET_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_idx] <= '0;
        end else if (touch_en) begin
            mem[touch_idx] <= plru_touch(mem[touch_idx], touch_way);
        end
    end

    assign rd_plru = mem[rd_idx];

endmodule

// File: rtl/dm_cache_tag_bram.sv
// Single-port tag RAM for one way; contents are not reset and must be swept by the owner.
// Latency: read is combinational at addra, write lands on the clock edge.
// Backpressure: none; always accepts a write when ena && wea.
module dm_cache_tag_bram
    import cache_def_pipe_data::*;
#(
    parameter int SET_NUM = 128
) (
    input  logic                       clk,
    input  logic                       ena,
    input  logic                       wea,
    input  logic [$clog2(SET_NUM)-1:0] addra,
    input  cache_tag_type              dina,
    output cache_tag_type              douta
);

    cache_tag_type mem [SET_NUM];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    assign douta = mem[addra];

endmodule

// File: rtl/cache_tag_ctrl.sv
// Tag-side controller for a 4-way cache: lookup/hit detect, dirty marking, victim pick, fill, flush sweep.
// Latency: response one cycle after accept; fill installs on the fill_valid edge; sweep takes SET_NUM cycles.
// Backpressure: req_ready low during sweep, while a miss waits for fill, and while flush_req is high.
module cache_tag_ctrl
    import cache_def_pipe_data::*;
#(
    parameter int SET_NUM = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_req,
    output logic                       init_done,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [$clog2(SET_NUM)-1:0] req_index,
    input  logic [TAG_W-1:0]           req_tag,
    input  logic                       req_write,
    output logic                       resp_valid,
    output logic                       resp_hit,
    output logic [1:0]                 resp_way,
    output logic                       resp_evict,
    output logic [TAG_W-1:0]           resp_evict_tag,
    input  logic                       fill_valid
);

    localparam int IW = $clog2(SET_NUM);

    ctrl_state_t   state, state_nxt;
    logic [IW-1:0] sweep_cnt;

    cache_tag_type rd_tag [WAYS];
    logic [WAYS-1:0] ram_wea;
    logic [IW-1:0] ram_addr;
    cache_tag_type ram_dina;

    logic [WAYS-1:0] hit_vec;
    logic          hit_any, inv_any;
    logic [1:0]    hit_way, inv_way, victim_way;
    plru_t         plru_rd;

    logic          plru_clr, plru_touch_en;
    logic [IW-1:0] plru_touch_idx;
    logic [1:0]    plru_touch_way;

    logic [IW-1:0]    index_q;
    logic [TAG_W-1:0] tag_q;
    logic             write_q;
    logic [1:0]       victim_q;

    logic accept;

    assign init_done = (state == ST_READY) || (state == ST_MISS_WAIT);
    assign req_ready = (state == ST_READY) && !flush_req;
    assign accept    = req_valid && req_ready;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        dm_cache_tag_bram #(.SET_NUM(SET_NUM)) u_bram (
            .clk   (clk),
            .ena   (1'b1),
            .wea   (ram_wea[g]),
            .addra (ram_addr),
            .dina  (ram_dina),
            .douta (rd_tag[g])
        );
    end

    cache_plru_array #(.SET_NUM(SET_NUM)) u_plru (
        .clk       (clk),
        .rst       (rst),
        .clr_en    (plru_clr),
        .clr_idx   (sweep_cnt),
        .touch_en  (plru_touch_en),
        .touch_idx (plru_touch_idx),
        .touch_way (plru_touch_way),
        .rd_idx    (req_index),
        .rd_plru   (plru_rd)
    );

    // Hit detection and victim selection; lowest-numbered way wins every tie
    always_comb begin
        hit_way = 2'd0;
        inv_way = 2'd0;
        inv_any = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = rd_tag[w].valid && (rd_tag[w].tag == req_tag);
        end
        for (int w = WAYS-1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = 2'(w);
            end
            if (!rd_tag[w].valid) begin
                inv_way = 2'(w);
                inv_any = 1'b1;
            end
        end
        hit_any    = |hit_vec;
        victim_way = inv_any ? inv_way : plru_victim(plru_rd);
    end

    // FSM next state plus RAM/PLRU write steering
    always_comb begin
        state_nxt      = state;
        ram_wea        = '0;
        ram_dina       = '0;
        ram_addr       = req_index;
        plru_clr       = 1'b0;
        plru_touch_en  = 1'b0;
        plru_touch_idx = req_index;
        plru_touch_way = hit_way;
        case (state)
            ST_INIT: begin
                ram_addr = sweep_cnt;
                ram_wea  = '1;
                plru_clr = 1'b1;
                if (sweep_cnt == IW'(SET_NUM-1)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (flush_req) begin
                    state_nxt = ST_INIT;
                end else if (req_valid) begin
                    if (hit_any) begin
                        plru_touch_en = 1'b1;
                        if (req_write && !rd_tag[hit_way].dirty) begin
                            ram_wea[hit_way] = 1'b1;
                            ram_dina         = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
                        end
                    end else begin
                        state_nxt = ST_MISS_WAIT;
                    end
                end
            end
            ST_MISS_WAIT: begin
                ram_addr       = index_q;
                plru_touch_idx = index_q;
                plru_touch_way = victim_q;
                if (fill_valid) begin
                    ram_wea[victim_q] = 1'b1;
                    ram_dina          = '{valid: 1'b1, dirty: write_q, tag: tag_q};
                    plru_touch_en     = 1'b1;
                    state_nxt         = ST_READY;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep counter runs only in INIT and wraps to 0 as the sweep completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt <= '0;
        end else if (state == ST_INIT) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end else begin
            sweep_cnt <= '0;
        end
    end

    // Latch the pending miss so the fill can be installed without the requester holding it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q  <= '0;
            tag_q    <= '0;
            write_q  <= 1'b0;
            victim_q <= 2'd0;
        end else if (accept && !hit_any) begin
            index_q  <= req_index;
            tag_q    <= req_tag;
            write_q  <= req_write;
            victim_q <= victim_way;
        end
    end

    // Registered response, one cycle after accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= 2'd0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
        end else begin
            resp_valid <= accept;
            if (accept) begin
                resp_hit       <= hit_any;
                resp_way       <= hit_any ? hit_way : victim_way;
                resp_evict     <= !hit_any && rd_tag[victim_way].valid && rd_tag[victim_way].dirty;
                resp_evict_tag <= rd_tag[victim_way].tag;
            end
        end
    end

    // Two ways holding the same valid tag means the fill path is broken upstream
    a_onehot_hit: assert property (@(posedge clk) disable iff (rst) accept |-> $onehot0(hit_vec));

endmodule
